// File: rtl/instr_sequencer.sv
// Top-level control FSM of the CPU core: fetches one- or two-word instructions,
// owns the PC (PLIMM-to-P3F jumps and CND skips) and sequences EXEC cycles.
module instr_sequencer #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [7:0]          OP_END    = 8'hFF,
  parameter logic [7:0]          OP_LIMM32 = 8'h11,
  parameter logic [7:0]          OP_LBSET  = 8'h20,
  parameter logic [7:0]          OP_PLIMM  = 8'h30,
  parameter logic [7:0]          OP_CND    = 8'h40,
  parameter logic [5:0]          PC_PREG   = 6'h3F
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [3:0]          current_state,
  output logic [31:0]         instr0,
  output logic [31:0]         instr1,
  input  logic [15:0]         mmu_addr,
  input  logic                mmu_invalid,
  input  logic                cnd_bit,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         retired
);

  // Codes are shared with the datapath's STATE_* decode.
  typedef enum logic [3:0] {
    ST_HLT    = 4'd0,
    ST_FETCH0 = 4'd1,
    ST_FETCH1 = 4'd2,
    ST_EXEC   = 4'd3,
    ST_FAULT  = 4'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr0_q, instr0_d;
  logic [31:0]         instr1_q, instr1_d;
  logic                skip_q, skip_d;
  logic [31:0]         retired_q, retired_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic [7:0]          exec_op;
  logic [7:0]          fetch_op;
  logic                fetch_two_word;
  logic [PC_WIDTH-1:0] pc_inc;

  assign exec_op        = instr0_q[31:24];
  assign fetch_op       = imem_rdata[31:24];
  assign fetch_two_word = (fetch_op == OP_LIMM32) || (fetch_op == OP_LBSET);
  assign pc_inc         = pc_q + PC_WIDTH'(1);

  // Handshake: imem_req is a pure decode of the state register, so it stays
  // high with imem_addr stable until a cycle where imem_ack=1 is sampled;
  // imem_rdata is taken in that same cycle. Acks outside a fetch are ignored.
  assign imem_req      = (state_q == ST_FETCH0) || (state_q == ST_FETCH1);
  assign imem_addr     = pc_q;
  assign current_state = state_q;
  assign instr0        = instr0_q;
  assign instr1        = instr1_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign retired       = retired_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr0_d  = instr0_q;
    instr1_d  = instr1_q;
    skip_d    = skip_q;
    retired_d = retired_q;

    case (state_q)
      ST_HLT, ST_FAULT: begin
        if (start) begin
          state_d = ST_FETCH0;
          pc_d    = RESET_PC;
          skip_d  = 1'b0;
        end
      end

      ST_FETCH0: begin
        if (imem_ack) begin
          instr0_d = imem_rdata;
          instr1_d = '0;
          pc_d     = pc_inc;
          if (fetch_two_word) begin
            state_d = ST_FETCH1;
          end else if (skip_q) begin
            skip_d  = 1'b0;
            state_d = ST_FETCH0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_FETCH1: begin
        if (imem_ack) begin
          instr1_d = imem_rdata;
          pc_d     = pc_inc;
          if (skip_q) begin
            skip_d  = 1'b0;
            state_d = ST_FETCH0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        retired_d = retired_q + 32'd1;
        // A rejected MMU request outranks every other outcome, including END.
        if (mmu_invalid) begin
          state_d = ST_FAULT;
        end else if (exec_op == OP_END) begin
          state_d = ST_HLT;
        end else if ((exec_op == OP_PLIMM) && (instr0_q[23:18] == PC_PREG)) begin
          pc_d    = PC_WIDTH'(mmu_addr);
          state_d = ST_FETCH0;
        end else if ((exec_op == OP_CND) && !cnd_bit) begin
          skip_d  = 1'b1;
          state_d = ST_FETCH0;
        end else begin
          state_d = ST_FETCH0;
        end
      end

      default: begin
        state_d = ST_HLT;
      end
    endcase

    halted_d = (state_d == ST_HLT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HLT;
      pc_q      <= RESET_PC;
      instr0_q  <= '0;
      instr1_q  <= '0;
      skip_q    <= 1'b0;
      retired_q <= '0;
      halted_q  <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr0_q  <= instr0_d;
      instr1_q  <= instr1_d;
      skip_q    <= skip_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a program-level reference model predicts the
// executed instruction stream, final pc, state and retired count.
module tb_instr_sequencer;

  localparam logic [7:0]  OP_LIMM16 = 8'h10;
  localparam logic [7:0]  OP_LIMM32 = 8'h11;
  localparam logic [7:0]  OP_LBSET  = 8'h20;
  localparam logic [7:0]  OP_PLIMM  = 8'h30;
  localparam logic [7:0]  OP_CND    = 8'h40;
  localparam logic [7:0]  OP_ALU    = 8'h55;
  localparam logic [7:0]  OP_END    = 8'hFF;
  localparam logic [5:0]  PC_PREG   = 6'h3F;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  localparam logic [3:0] S_HLT    = 4'd0;
  localparam logic [3:0] S_FETCH0 = 4'd1;
  localparam logic [3:0] S_FETCH1 = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_FAULT  = 4'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [3:0]  current_state;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic [15:0] mmu_addr;
  logic        mmu_invalid;
  logic        cnd_bit;
  logic [15:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:65535];
  logic [63:0] exp_q[$];
  logic [3:0]  st_trace[$];
  logic [15:0] addr_trace[$];
  logic [3:0]  exp_end_state;
  logic [15:0] exp_pc;
  logic [31:0] exp_retired = 32'd0;

  instr_sequencer #(
    .PC_WIDTH(16), .RESET_PC(RESET_PC), .OP_END(OP_END), .OP_LIMM32(OP_LIMM32),
    .OP_LBSET(OP_LBSET), .OP_PLIMM(OP_PLIMM), .OP_CND(OP_CND), .PC_PREG(PC_PREG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .current_state(current_state), .instr0(instr0), .instr1(instr1),
    .mmu_addr(mmu_addr), .mmu_invalid(mmu_invalid), .cnd_bit(cnd_bit),
    .pc(pc), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Word layout: opcode[31:24], preg[23:18], bit17 = mock MMU rejects, imm[15:0].
  // The mock datapath reads cnd_bit from imm[0] and the MMU address from imm.
  function automatic logic [31:0] mk(input logic [7:0] op, input logic [5:0] preg,
                                     input logic flt, input logic [15:0] imm);
    return {op, preg, flt, 1'b0, imm};
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = mk(OP_END, 6'd0, 1'b0, 16'd0);
  endtask

  // Program-level model: walk instructions from RESET_PC, apply skip/jump/halt rules.
  task automatic model_run();
    logic [15:0] p;
    logic        sk;
    logic [31:0] w0, w1;
    logic [7:0]  op;
    bit          done;
    exp_q.delete();
    p = RESET_PC; sk = 1'b0; done = 0; exp_end_state = S_HLT;
    for (int steps = 0; steps < 4000 && !done; steps++) begin
      w0 = mem[p]; p = p + 16'd1; op = w0[31:24]; w1 = 32'd0;
      if (op == OP_LIMM32 || op == OP_LBSET) begin
        w1 = mem[p]; p = p + 16'd1;
      end
      if (sk) begin
        sk = 1'b0;
      end else begin
        exp_retired = exp_retired + 32'd1;
        exp_q.push_back({w0, w1});
        if (w0[17]) begin
          exp_end_state = S_FAULT; done = 1;
        end else if (op == OP_END) begin
          exp_end_state = S_HLT; done = 1;
        end else if (op == OP_PLIMM && w0[23:18] == PC_PREG) begin
          p = w0[15:0];
        end else if (op == OP_CND && !w0[0]) begin
          sk = 1'b1;
        end
      end
    end
    exp_pc = p;
  endtask

  // Runs the DUT until it reaches HLT or FAULT, acting as memory, MMU and datapath.
  task automatic run_prog(input bit do_start, input int dmin, input int dmax, input bit noise);
    logic [3:0]  st;
    logic [63:0] e;
    logic [15:0] held_addr;
    bit          held, finished;
    int          wait_left;
    model_run();
    st_trace.delete();
    addr_trace.delete();
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    held = 0; finished = 0; wait_left = 0; held_addr = 16'd0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      st = current_state;
      if (st == S_HLT || st == S_FAULT) begin
        finished = 1;
      end else begin
        st_trace.push_back(st);
        start       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        mmu_addr    = 16'($urandom);
        cnd_bit     = 1'($urandom);
        mmu_invalid = noise ? 1'($urandom) : 1'b0;
        checks++;
        if (imem_req !== (st == S_FETCH0 || st == S_FETCH1)) begin
          failures++;
          $display("FAIL req_decode: imem_req=%0b in state %0d", imem_req, st);
        end
        if (st == S_EXEC) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_exec: instr0=%h executed, none expected", instr0);
          end else begin
            e = exp_q.pop_front();
            if ({instr0, instr1} !== e) begin
              failures++;
              $display("FAIL exec_instr: got %h_%h expected %h_%h", instr0, instr1, e[63:32], e[31:0]);
            end
          end
          mmu_addr    = instr0[15:0];
          cnd_bit     = instr0[0];
          mmu_invalid = instr0[17];
        end
        if (imem_req) begin
          if (!held) begin
            held = 1; held_addr = imem_addr;
            wait_left = $urandom_range(dmax, dmin);
            addr_trace.push_back(imem_addr);
          end else begin
            checks++;
            if (imem_addr !== held_addr) begin
              failures++;
              $display("FAIL addr_stable: imem_addr=%h held=%h", imem_addr, held_addr);
            end
          end
          if (wait_left == 0) begin
            imem_ack = 1'b1; imem_rdata = mem[held_addr]; held = 0;
          end else begin
            wait_left--;
          end
        end else if (noise && $urandom_range(3, 0) == 0) begin
          imem_ack = 1'b1;
        end
        if (noise && $urandom_range(7, 0) == 0) start = 1'b1;
        @(negedge clk);
      end
    end
    imem_ack = 1'b0; start = 1'b0; mmu_invalid = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL timeout: state=%0d did not stop", current_state);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_exec: %0d expected instructions not executed", exp_q.size());
    end
    checks++;
    if (current_state !== exp_end_state || pc !== exp_pc || retired !== exp_retired) begin
      failures++;
      $display("FAIL end_status: state=%0d pc=%h retired=%0d expected state=%0d pc=%h retired=%0d",
               current_state, pc, retired, exp_end_state, exp_pc, exp_retired);
    end
    checks++;
    if (halted !== (exp_end_state == S_HLT) || fault !== (exp_end_state == S_FAULT)) begin
      failures++;
      $display("FAIL end_flags: halted=%0b fault=%0b expected end state %0d", halted, fault, exp_end_state);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    checks++;
    if (current_state !== S_HLT || imem_req !== 1'b0 || instr0 !== 32'd0 || instr1 !== 32'd0 ||
        retired !== 32'd0 || pc !== RESET_PC || halted !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("FAIL %s: state=%0d req=%0b i0=%h i1=%h ret=%0d pc=%h h=%0b f=%0b expected 0,0,0,0,0,%h,1,0",
               tag, current_state, imem_req, instr0, instr1, retired, pc, halted, fault, RESET_PC);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    mmu_addr = 16'd0; mmu_invalid = 1'b0; cnd_bit = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset("reset_asserted");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_reset("reset_released");
    exp_retired = 32'd0;
  endtask

  task automatic test_basic();
    logic [3:0] want [4];
    want = '{S_FETCH0, S_EXEC, S_FETCH0, S_EXEC};
    clear_mem();
    mem[0] = mk(OP_LIMM16, 6'd1, 1'b0, 16'd5);
    mem[1] = mk(OP_END, 6'd0, 1'b0, 16'd0);
    run_prog(1, 0, 0, 0);
    checks++;
    if (st_trace.size() != 4) begin
      failures++;
      $display("FAIL basic_trace_len: got %0d states expected 4", st_trace.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (st_trace[i] !== want[i]) begin
          failures++;
          $display("FAIL basic_trace[%0d]: got %0d expected %0d", i, st_trace[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_two_word_delay();
    logic [3:0] want [9];
    want = '{S_FETCH0, S_FETCH0, S_FETCH0, S_FETCH0, S_FETCH1, S_FETCH1, S_FETCH1, S_FETCH1, S_EXEC};
    clear_mem();
    mem[0] = mk(OP_LIMM32, 6'd2, 1'b0, 16'd0);
    mem[1] = 32'hDEADBEEF;
    run_prog(1, 3, 3, 0);
    checks++;
    if (st_trace.size() < 9) begin
      failures++;
      $display("FAIL delay_trace_len: got %0d states expected at least 9", st_trace.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (st_trace[i] !== want[i]) begin
          failures++;
          $display("FAIL delay_trace[%0d]: got %0d expected %0d", i, st_trace[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_cnd_skip();
    clear_mem();
    mem[0] = mk(OP_CND, 6'd1, 1'b0, 16'd0);
    mem[1] = mk(OP_LBSET, 6'd2, 1'b0, 16'h1234);
    mem[2] = 32'hCAFE0001;
    run_prog(1, 0, 2, 0);
    // CND followed by CND: only one instruction is skipped.
    clear_mem();
    mem[0] = mk(OP_CND, 6'd1, 1'b0, 16'd0);
    mem[1] = mk(OP_CND, 6'd1, 1'b0, 16'd0);
    mem[2] = mk(OP_LIMM16, 6'd3, 1'b0, 16'd9);
    mem[3] = mk(OP_CND, 6'd1, 1'b0, 16'd1);
    mem[4] = mk(OP_LIMM32, 6'd3, 1'b0, 16'd0);
    mem[5] = 32'h0BADF00D;
    run_prog(1, 0, 1, 0);
  endtask

  task automatic test_plimm();
    clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = mk(OP_ALU, 6'd0, 1'b1, 16'd0);
    mem[0]     = mk(OP_PLIMM, PC_PREG, 1'b0, 16'h0040);
    mem[16'h40] = mk(OP_END, 6'd0, 1'b0, 16'd0);
    run_prog(1, 0, 1, 0);
    checks++;
    if (addr_trace.size() < 2 || addr_trace[1] !== 16'h0040) begin
      failures++;
      $display("FAIL plimm_jump_addr: second fetch addr=%h expected 0040",
               addr_trace.size() > 1 ? addr_trace[1] : 16'hxxxx);
    end
    clear_mem();
    mem[0] = mk(OP_PLIMM, 6'h01, 1'b0, 16'h0040);
    run_prog(1, 0, 1, 0);
    checks++;
    if (addr_trace.size() < 2 || addr_trace[1] !== 16'h0001) begin
      failures++;
      $display("FAIL plimm_nojump_addr: second fetch addr=%h expected 0001",
               addr_trace.size() > 1 ? addr_trace[1] : 16'hxxxx);
    end
  endtask

  task automatic test_fault_restart();
    clear_mem();
    mem[0] = mk(OP_LIMM16, 6'd1, 1'b0, 16'd5);
    mem[1] = mk(OP_PLIMM, PC_PREG, 1'b1, 16'h0100);
    run_prog(1, 0, 1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (current_state !== S_FETCH0 || pc !== RESET_PC || fault !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL fault_restart: state=%0d pc=%h fault=%0b halted=%0b expected 1,%h,0,0",
               current_state, pc, fault, halted, RESET_PC);
    end
    mem[1] = mk(OP_END, 6'd0, 1'b1, 16'd0);
    run_prog(0, 0, 1, 0);
    clear_mem();
    mem[0] = mk(OP_LIMM16, 6'd1, 1'b0, 16'd5);
    run_prog(1, 0, 0, 0);
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]       = mk(OP_PLIMM, PC_PREG, 1'b0, 16'hFFFE);
    mem[16'hFFFE] = mk(OP_LIMM16, 6'd4, 1'b0, 16'd7);
    mem[16'hFFFF] = mk(OP_LIMM32, 6'd4, 1'b0, 16'd0);
    run_prog(1, 0, 2, 0);
  endtask

  task automatic gen_random();
    int          i, len, k;
    logic [7:0]  op;
    logic [5:0]  preg;
    logic [15:0] imm;
    clear_mem();
    len = $urandom_range(40, 12);
    i = 0;
    while (i < len) begin
      k = $urandom_range(9, 0);
      imm = 16'($urandom);
      preg = 6'($urandom_range(62, 0));
      case (k)
        0, 1: op = OP_LIMM16;
        2:    op = OP_LIMM32;
        3:    op = OP_LBSET;
        4, 5: begin
          op = OP_PLIMM;
          if ($urandom_range(1, 0) == 1) begin
            preg = PC_PREG;
            imm = 16'($urandom_range(len + 3, i + 1));
          end
        end
        6, 7: op = OP_CND;
        8:    op = OP_ALU;
        default: op = ($urandom_range(3, 0) == 0) ? OP_END : OP_LIMM16;
      endcase
      mem[i] = mk(op, preg, ($urandom_range(29, 0) == 0), imm);
      i++;
      if (op == OP_LIMM32 || op == OP_LBSET) begin
        mem[i] = {OP_LIMM16, 24'($urandom)};
        i++;
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      gen_random();
      run_prog(1, 0, $urandom_range(3, 0), 1);
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_mem();
    mem[0] = mk(OP_LIMM32, 6'd2, 1'b0, 16'd0);
    mem[1] = 32'h12345678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem[0];
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (current_state !== S_FETCH1 || imem_req !== 1'b1 || instr0 !== mem[0]) begin
      failures++;
      $display("FAIL mid_fetch_setup: state=%0d req=%0b i0=%h expected 2,1,%h",
               current_state, imem_req, instr0, mem[0]);
    end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_reset("reset_mid_fetch");
    @(negedge clk);
    reset_n = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    check_idle_reset("after_mid_fetch_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_word_delay();
    test_cnd_skip();
    test_plimm();
    test_fault_restart();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
